// File: rtl/rc4_crack_core_pkg.sv
// rtl/rc4_crack_core_pkg.sv - shared types and constants for the RC4 key-search core
package rc4_crack_core_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RI,
    ST_K_RJ,
    ST_K_SI,
    ST_K_SJ,
    ST_P_RI,
    ST_P_RJ,
    ST_P_SI,
    ST_P_SJ,
    ST_P_RF,
    ST_P_CK,
    ST_NEXT_KEY
  } rc4_state_e;

  localparam logic [7:0] CH_LO = 8'h61;
  localparam logic [7:0] CH_HI = 8'h7A;
  localparam logic [7:0] CH_SP = 8'h20;

  function automatic logic is_printable(input logic [7:0] b);
    return (b == CH_SP) || ((b >= CH_LO) && (b <= CH_HI));
  endfunction

endpackage

// File: rtl/rc4_crack_core_if.sv
// rtl/rc4_crack_core_if.sv - control handshake and memory ports of one search core
interface rc4_crack_core_if #(
  parameter int KEY_BITS = 24,
  parameter int MSG_AW   = 5
);
  logic                start;
  logic                abort;
  logic [7:0]          s_addr;
  logic [7:0]          s_wdata;
  logic                s_wren;
  logic [7:0]          s_q;
  logic [MSG_AW-1:0]   rom_addr;
  logic [7:0]          rom_q;
  logic [MSG_AW-1:0]   msg_addr;
  logic [7:0]          msg_data;
  logic                msg_wren;
  logic                busy;
  logic                found;
  logic                exhausted;
  logic [KEY_BITS-1:0] key;

  modport master (
    input  start, abort, s_q, rom_q,
    output s_addr, s_wdata, s_wren, rom_addr, msg_addr, msg_data, msg_wren,
           busy, found, exhausted, key
  );

  modport slave (
    output start, abort, s_q, rom_q,
    input  s_addr, s_wdata, s_wren, rom_addr, msg_addr, msg_data, msg_wren,
           busy, found, exhausted, key
  );
endinterface

// File: rtl/rc4_crack_core_key_stepper.sv
// rtl/rc4_crack_core_key_stepper.sv - candidate key register, strided advance and range end detection
module rc4_crack_core_key_stepper #(
  parameter int              KEY_BITS   = 24,
  parameter longint unsigned KEY_FIRST  = 0,
  parameter longint unsigned KEY_STRIDE = 1,
  parameter longint unsigned KEY_LAST   = 64'd4194303
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic                step_i,
  output logic [KEY_BITS-1:0] key_o,
  output logic                over_o,
  output logic                exhausted_o
);
  localparam logic [KEY_BITS-1:0] FIRST_W  = KEY_BITS'(KEY_FIRST);
  localparam logic [KEY_BITS:0]   STRIDE_W = (KEY_BITS+1)'(KEY_STRIDE);
  localparam logic [KEY_BITS:0]   LAST_W   = (KEY_BITS+1)'(KEY_LAST);

  logic [KEY_BITS-1:0] key_q, key_d;
  logic                exh_q, exh_d;
  logic [KEY_BITS:0]   sum;

  // One extra bit so a stride that wraps the key width still counts as past the end
  assign sum    = {1'b0, key_q} + STRIDE_W;
  assign over_o = (sum > LAST_W);

  always_comb begin
    key_d = key_q;
    exh_d = exh_q;
    if (load_i) begin
      key_d = FIRST_W;
      exh_d = 1'b0;
    end else if (step_i) begin
      if (over_o) exh_d = 1'b1;
      else        key_d = sum[KEY_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= FIRST_W;
      exh_q <= 1'b0;
    end else begin
      key_q <= key_d;
      exh_q <= exh_d;
    end
  end

  assign key_o       = key_q;
  assign exhausted_o = exh_q;
endmodule

// File: rtl/rc4_crack_core.sv
// rtl/rc4_crack_core.sv - RC4 brute-force engine: S init, key schedule and keystream check per candidate
module rc4_crack_core
  import rc4_crack_core_pkg::*;
#(
  parameter int              KEY_BITS   = 24,
  parameter longint unsigned KEY_FIRST  = 0,
  parameter longint unsigned KEY_STRIDE = 1,
  parameter longint unsigned KEY_LAST   = 64'd4194303,
  parameter int              MSG_LEN    = 32
) (
  input logic                clk,
  input logic                reset_n,
  rc4_crack_core_if.master   bus
);
  localparam int MSG_AW    = $clog2(MSG_LEN);
  localparam int KEY_BYTES = KEY_BITS / 8;
  localparam int KB_W      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  rc4_state_e        state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [KB_W-1:0]   kb_q, kb_d;
  logic              found_q, found_d, busy_q, busy_d;

  logic                key_load, key_step, key_over, key_exh;
  logic [KEY_BITS-1:0] key_w;
  logic [7:0]          key_byte, b_w;

  rc4_crack_core_key_stepper #(
    .KEY_BITS(KEY_BITS), .KEY_FIRST(KEY_FIRST), .KEY_STRIDE(KEY_STRIDE), .KEY_LAST(KEY_LAST)
  ) u_key (
    .clk(clk), .reset_n(reset_n), .load_i(key_load), .step_i(key_step),
    .key_o(key_w), .over_o(key_over), .exhausted_o(key_exh)
  );

  // Byte 0 is the most significant key byte
  always_comb begin
    key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++)
      if (kb_q == KB_W'(n)) key_byte = key_w[KEY_BITS-1-8*n -: 8];
  end

  assign b_w = bus.s_q ^ bus.rom_q;

  always_comb begin
    state_d = state_q;
    i_d = i_q; j_d = j_q; si_d = si_q; sj_d = sj_q; k_d = k_q; kb_d = kb_q;
    found_d = found_q; busy_d = busy_q;
    key_load = 1'b0; key_step = 1'b0;
    bus.s_addr = 8'h00; bus.s_wdata = 8'h00; bus.s_wren = 1'b0;
    bus.rom_addr = '0; bus.msg_addr = '0; bus.msg_data = 8'h00; bus.msg_wren = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        found_d = 1'b0; busy_d = 1'b1; key_load = 1'b1; i_d = 8'h00; state_d = ST_INIT;
      end
      ST_INIT: begin
        bus.s_addr = i_q; bus.s_wdata = i_q; bus.s_wren = 1'b1;
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d = 8'h00; kb_d = '0; state_d = ST_K_RI;
        end
      end
      ST_K_RI: begin
        bus.s_addr = i_q; state_d = ST_K_RJ;
      end
      ST_K_RJ: begin
        si_d = bus.s_q; j_d = j_q + bus.s_q + key_byte; bus.s_addr = j_d; state_d = ST_K_SI;
      end
      ST_K_SI: begin
        sj_d = bus.s_q; bus.s_addr = i_q; bus.s_wdata = bus.s_q; bus.s_wren = 1'b1; state_d = ST_K_SJ;
      end
      ST_K_SJ: begin
        bus.s_addr = j_q; bus.s_wdata = si_q; bus.s_wren = 1'b1;
        i_d  = i_q + 8'd1;
        kb_d = (kb_q == KB_W'(KEY_BYTES-1)) ? '0 : kb_q + 1'b1;
        state_d = ST_K_RI;
        if (i_q == 8'hFF) begin
          j_d = 8'h00; k_d = '0; state_d = ST_P_RI;
        end
      end
      ST_P_RI: begin
        i_d = i_q + 8'd1; bus.s_addr = i_d; state_d = ST_P_RJ;
      end
      ST_P_RJ: begin
        si_d = bus.s_q; j_d = j_q + bus.s_q; bus.s_addr = j_d; state_d = ST_P_SI;
      end
      ST_P_SI: begin
        sj_d = bus.s_q; bus.s_addr = i_q; bus.s_wdata = bus.s_q; bus.s_wren = 1'b1; state_d = ST_P_SJ;
      end
      ST_P_SJ: begin
        bus.s_addr = j_q; bus.s_wdata = si_q; bus.s_wren = 1'b1; state_d = ST_P_RF;
      end
      ST_P_RF: begin
        bus.s_addr = si_q + sj_q; bus.rom_addr = k_q; state_d = ST_P_CK;
      end
      ST_P_CK: begin
        bus.msg_addr = k_q; bus.msg_data = b_w; bus.msg_wren = 1'b1;
        if (!is_printable(b_w)) begin
          state_d = ST_NEXT_KEY;
        end else if (k_q == MSG_AW'(MSG_LEN-1)) begin
          found_d = 1'b1; busy_d = 1'b0; state_d = ST_IDLE;
        end else begin
          k_d = k_q + 1'b1; state_d = ST_P_RI;
        end
      end
      ST_NEXT_KEY: begin
        key_step = 1'b1;
        if (key_over) begin
          busy_d = 1'b0; state_d = ST_IDLE;
        end else begin
          i_d = 8'h00; state_d = ST_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A success on the final byte outranks a simultaneous abort
    if (bus.abort && (state_q != ST_IDLE) && !found_d) begin
      state_d = ST_IDLE; busy_d = 1'b0; key_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q <= 8'h00; j_q <= 8'h00; si_q <= 8'h00; sj_q <= 8'h00;
      k_q <= '0; kb_q <= '0;
      found_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d; j_q <= j_d; si_q <= si_d; sj_q <= sj_d;
      k_q <= k_d; kb_q <= kb_d;
      found_q <= found_d; busy_q <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.found     = found_q;
  assign bus.exhausted = key_exh;
  assign bus.key       = key_w;
endmodule
